// File: rtl/dpc_kbd_pkg.sv
// Shared keyboard definitions: key code width, matrix size and the queued event record.
package dpc_kbd_pkg;

  localparam int unsigned KEY_CODE_WIDTH = 6;
  localparam int unsigned KEY_NUM_MAX    = 40;

  typedef struct packed {
    logic [KEY_CODE_WIDTH-1:0] code;
    logic                      pressed;
  } key_event_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO of key events with occupancy count, full and empty flags.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo
  import dpc_kbd_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  key_event_t               wdata,
  input  logic                     pop,
  output key_event_t               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  key_event_t            mem [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];

  // Pointer and occupancy next state; pointers wrap naturally as DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/key_event_queue.sv
// Keyboard matrix debouncer feeding an event queue.
// Each key is debounced over DEBOUNCE_SCANS consecutive differing scans; accepted changes
// set a pending bit, the lowest pending key is pushed into the FIFO each cycle.
// Build option: define KEY_RELEASE_EVENTS_EN to also queue release events; otherwise only
// presses are queued and evtPressed reads 1 whenever an event is valid.
module key_event_queue
  import dpc_kbd_pkg::*;
#(
  parameter int unsigned KEY_NUM        = 40,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned DEPTH          = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [KEY_NUM-1:0]       keysCurrentState,
  input  logic                     scanDone,
  output logic                     evtValid,
  output logic [5:0]               evtCode,
  output logic                     evtPressed,
  input  logic                     evtReady,
  output logic                     overflow,
  input  logic                     clearOverflow,
  output logic [$clog2(DEPTH):0]   count
);

`ifdef KEY_RELEASE_EVENTS_EN
  localparam bit RelEvtEn = 1'b1;
`else
  localparam bit RelEvtEn = 1'b0;
`endif

  logic [KEY_NUM-1:0]       deb_q, deb_d;
  logic [KEY_NUM-1:0][2:0]  cnt_q, cnt_d;
  logic [KEY_NUM-1:0]       pend_q, pend_d;
  logic                     ovf_q, ovf_d;

  logic                     sel_valid;
  logic [5:0]               sel_idx;
  key_event_t               push_evt, head_evt;
  logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;

  // Priority encoder: lowest-index pending key wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = int'(KEY_NUM) - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = 6'(i);
      end
    end
  end

  // Direction is sampled from the debounced state at push time, not at toggle time.
  assign push_evt.code    = sel_idx;
  assign push_evt.pressed = deb_q[sel_idx];

  assign fifo_pop  = evtReady & ~fifo_empty;
  assign fifo_push = sel_valid & (~fifo_full | fifo_pop);

  // Debounce counters, debounced state and pending bits; a new toggle beats the pending clear.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (sel_valid) pend_d[sel_idx] = 1'b0;
    if (scanDone) begin
      for (int i = 0; i < int'(KEY_NUM); i++) begin
        if (keysCurrentState[i] == deb_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] + 3'd1 == 3'(DEBOUNCE_SCANS)) begin
          deb_d[i] = ~deb_q[i];
          cnt_d[i] = '0;
          if (RelEvtEn || !deb_q[i]) pend_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 3'd1;
        end
      end
    end
  end

  // Sticky overflow: a dropped event outranks a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clearOverflow) ovf_d = 1'b0;
    if (sel_valid && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  // Debounce and status registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      deb_q  <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (fifo_push),
    .wdata (push_evt),
    .pop   (fifo_pop),
    .rdata (head_evt),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evtValid = ~fifo_empty;
  assign evtCode  = fifo_empty ? 6'd0 : head_evt.code;
  assign overflow = ovf_q;
`ifdef KEY_RELEASE_EVENTS_EN
  assign evtPressed = ~fifo_empty & head_evt.pressed;
`else
  assign evtPressed = ~fifo_empty;
`endif

endmodule
